textlcd_sched: RTL and testbench

Text-LCD access scheduler for the 16x2 character module (HD44780-style, 8-bit bus). It runs the power-on init sequence itself. It then serves character-write requests from two independent requesters under round-robin arbitration, turning each request into a Set-DDRAM-Address command followed by a data write. It sits between the application logic and the LCD pins and is the only driver of LCD_E/LCD_RS/LCD_RW/LCD_DATA.

---
 rtl/textlcd_sched_if.sv | 28 ++
 rtl/textlcd_sched.sv | 221 ++++++++++++++++++++++
 tb/tb_textlcd_sched.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/textlcd_sched_if.sv
// Request/grant bundle and LCD pin group for textlcd_sched.
// Handshake: reqN and its line/col/char are held by the requester until doneN.
// gntN marks service in progress, and doneN pulses once when the character is on the glass.
interface textlcd_sched_if;
  logic       req0, req1;
  logic       line0, line1;
  logic [3:0] col0, col1;
  logic [7:0] char0, char1;
  logic       gnt0, gnt1;
  logic       done0, done1;
  logic       ready;
  logic       LCD_E;
  logic       LCD_RS;
  logic       LCD_RW;
  logic [7:0] LCD_DATA;

  modport slave (
    input  req0, req1, line0, line1, col0, col1, char0, char1,
    output gnt0, gnt1, done0, done1, ready,
    output LCD_E, LCD_RS, LCD_RW, LCD_DATA
  );

  modport master (
    output req0, req1, line0, line1, col0, col1, char0, char1,
    input  gnt0, gnt1, done0, done1, ready,
    input  LCD_E, LCD_RS, LCD_RW, LCD_DATA
  );
endinterface

// File: rtl/textlcd_sched.sv
// HD44780 16x2 scheduler: power-on init, then round-robin character writes from two requesters.
// Optional macro TEXTLCD_AUTOINC_EN: track the LCD cursor and skip the address command when it already matches.
module textlcd_sched #(
  parameter int INIT_WAIT = 70,
  parameter int XFER_CYC  = 8,
  parameter int CLR_WAIT  = 200
) (
  input  logic              clk,
  input  logic              resetn,
  textlcd_sched_if.slave    bus,
  output logic [2:0]        state_o
);

  localparam int M1      = (INIT_WAIT > CLR_WAIT) ? INIT_WAIT : CLR_WAIT;
  localparam int CNT_MAX = (M1 > XFER_CYC) ? M1 : XFER_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] INIT_LAST = CW'(INIT_WAIT - 1);
  localparam logic [CW-1:0] XFER_LAST = CW'(XFER_CYC - 1);
  localparam logic [CW-1:0] CLR_LAST  = CW'(CLR_WAIT - 1);
  localparam logic [CW-1:0] E_LAST    = CW'(XFER_CYC / 2);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_WAIT_PWR = 3'd0,
    S_INIT     = 3'd1,
    S_CLR_HOLD = 3'd2,
    S_IDLE     = 3'd3,
    S_ADDR     = 3'd4,
    S_DATA     = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          rr_q, rr_d;     // 1: req1 wins a tie
  logic          sel_q, sel_d;   // requester currently served
  logic [6:0]    addr_q, addr_d;
  logic [7:0]    char_q, char_d;
  logic [7:0]    bus_q, bus_d;
  logic          rs_q, rs_d;
  logic          ready_q, ready_d;
`ifdef TEXTLCD_AUTOINC_EN
  logic [6:0]    cursor_q, cursor_d;
`endif

  logic       xfer_last;
  logic       pick;
  logic [6:0] new_addr;
  logic [7:0] new_char;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    init_cmd = 8'h3C;
      2'd1:    init_cmd = 8'h0C;
      2'd2:    init_cmd = 8'h06;
      default: init_cmd = 8'h01;
    endcase
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_WAIT_PWR;
      cnt_q    <= '0;
      idx_q    <= '0;
      rr_q     <= 1'b0;
      sel_q    <= 1'b0;
      addr_q   <= '0;
      char_q   <= '0;
      bus_q    <= '0;
      rs_q     <= 1'b0;
      ready_q  <= 1'b0;
`ifdef TEXTLCD_AUTOINC_EN
      cursor_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      rr_q     <= rr_d;
      sel_q    <= sel_d;
      addr_q   <= addr_d;
      char_q   <= char_d;
      bus_q    <= bus_d;
      rs_q     <= rs_d;
      ready_q  <= ready_d;
`ifdef TEXTLCD_AUTOINC_EN
      cursor_q <= cursor_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    rr_d      = rr_q;
    sel_d     = sel_q;
    addr_d    = addr_q;
    char_d    = char_q;
    bus_d     = bus_q;
    rs_d      = rs_q;
    ready_d   = ready_q;
`ifdef TEXTLCD_AUTOINC_EN
    cursor_d  = cursor_q;
`endif
    xfer_last = (cnt_q == XFER_LAST);
    // On a tie the round-robin pointer decides, otherwise the lone requester wins.
    pick      = (bus.req0 && bus.req1) ? rr_q : bus.req1;
    new_addr  = pick ? {bus.line1, 2'b00, bus.col1} : {bus.line0, 2'b00, bus.col0};
    new_char  = pick ? bus.char1 : bus.char0;

    case (state_q)
      S_WAIT_PWR: begin
        if (cnt_q == INIT_LAST) begin
          state_d = S_INIT;
          cnt_d   = '0;
          idx_d   = 2'd0;
          bus_d   = init_cmd(2'd0);
          rs_d    = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_INIT: begin
        if (xfer_last) begin
          cnt_d = '0;
          if (idx_q == 2'd3) begin
            state_d  = S_CLR_HOLD;
`ifdef TEXTLCD_AUTOINC_EN
            cursor_d = '0;
`endif
          end else begin
            idx_d = idx_q + 2'd1;
            bus_d = init_cmd(idx_q + 2'd1);
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_CLR_HOLD: begin
        if (cnt_q == CLR_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          ready_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          sel_d  = pick;
          rr_d   = ~pick;
          addr_d = new_addr;
          char_d = new_char;
          cnt_d  = '0;
`ifdef TEXTLCD_AUTOINC_EN
          if (new_addr == cursor_q) begin
            state_d = S_DATA;
            bus_d   = new_char;
            rs_d    = 1'b1;
          end else begin
            state_d = S_ADDR;
            bus_d   = {1'b1, new_addr};
            rs_d    = 1'b0;
          end
`else
          state_d = S_ADDR;
          bus_d   = {1'b1, new_addr};
          rs_d    = 1'b0;
`endif
        end
      end
      S_ADDR: begin
        if (xfer_last) begin
          state_d  = S_DATA;
          cnt_d    = '0;
          bus_d    = char_q;
          rs_d     = 1'b1;
`ifdef TEXTLCD_AUTOINC_EN
          cursor_d = addr_q;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DATA: begin
        if (xfer_last) begin
          state_d  = S_IDLE;
          cnt_d    = '0;
`ifdef TEXTLCD_AUTOINC_EN
          cursor_d = cursor_q + 7'd1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_WAIT_PWR;
        cnt_d   = '0;
      end
    endcase
  end

  logic in_xfer;
  logic serving;
  assign in_xfer = (state_q == S_INIT) || (state_q == S_ADDR) || (state_q == S_DATA);
  assign serving = (state_q == S_ADDR) || (state_q == S_DATA);

  assign bus.LCD_E    = in_xfer && (cnt_q >= CNT_ONE) && (cnt_q <= E_LAST);
  assign bus.LCD_RS   = rs_q;
  assign bus.LCD_RW   = 1'b0;
  assign bus.LCD_DATA = bus_q;
  assign bus.gnt0     = serving && !sel_q;
  assign bus.gnt1     = serving && sel_q;
  assign bus.done0    = (state_q == S_DATA) && xfer_last && !sel_q;
  assign bus.done1    = (state_q == S_DATA) && xfer_last && sel_q;
  assign bus.ready    = ready_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_textlcd_sched.sv
// Directed bench for textlcd_sched: init sequence, single and round-robin service, latch, reset replay.
module tb_textlcd_sched;
  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] state;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] init_cmds [4] = '{8'h3C, 8'h0C, 8'h06, 8'h01};

  textlcd_sched_if bus ();

  textlcd_sched dut (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus.slave),
    .state_o (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_e"},     32'(bus.LCD_E),    32'd0);
    chk({tag, "_rs"},    32'(bus.LCD_RS),   32'd0);
    chk({tag, "_rw"},    32'(bus.LCD_RW),   32'd0);
    chk({tag, "_data"},  32'(bus.LCD_DATA), 32'd0);
    chk({tag, "_gnt0"},  32'(bus.gnt0),     32'd0);
    chk({tag, "_gnt1"},  32'(bus.gnt1),     32'd0);
    chk({tag, "_done0"}, 32'(bus.done0),    32'd0);
    chk({tag, "_done1"}, 32'(bus.done1),    32'd0);
    chk({tag, "_ready"}, 32'(bus.ready),    32'd0);
    chk({tag, "_state"}, 32'(state),        32'd0);
  endtask

  // Entered at the negedge where resetn was released (cycle 0); returns at cycle 302.
  task automatic run_init();
    int i;
    int k;
    for (int c = 1; c <= 302; c++) begin
      @(negedge clk);
      if (c == 69) begin
        chk("pwr_e",    32'(bus.LCD_E),    32'd0);
        chk("pwr_data", 32'(bus.LCD_DATA), 32'd0);
      end
      if (c >= 70 && c <= 101) begin
        i = (c - 70) / 8;
        k = (c - 70) % 8;
        chk("init_data", 32'(bus.LCD_DATA), 32'(init_cmds[i]));
        chk("init_rs",   32'(bus.LCD_RS),   32'd0);
        chk("init_e",    32'(bus.LCD_E),    32'(k >= 1 && k <= 4));
      end
      if (c == 150) begin
        chk("clr_hold_data", 32'(bus.LCD_DATA), 32'h01);
        chk("clr_hold_e",    32'(bus.LCD_E),    32'd0);
        chk("noready_gnt0",  32'(bus.gnt0),     32'd0);
        chk("noready_gnt1",  32'(bus.gnt1),     32'd0);
      end
      if (c == 301) chk("ready_early", 32'(bus.ready), 32'd0);
      if (c == 302) begin
        chk("ready_at_302", 32'(bus.ready), 32'd1);
        chk("idle_at_302",  32'(state),     32'd3);
      end
    end
  endtask

  // Called in IDLE with a request pending; the grant edge is the next posedge.
  task automatic serve(input int sel, input bit skip, input logic [7:0] cmd,
                       input logic [7:0] ch, input bit scramble, input bit drop);
    int n;
    n = skip ? 8 : 16;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      chk("gnt0", 32'(bus.gnt0), 32'(sel == 0));
      chk("gnt1", 32'(bus.gnt1), 32'(sel == 1));
      if (!skip && k < 8) begin
        chk("addr_cmd", 32'(bus.LCD_DATA), 32'(cmd));
        chk("addr_rs",  32'(bus.LCD_RS),   32'd0);
      end else begin
        chk("data_char", 32'(bus.LCD_DATA), 32'(ch));
        chk("data_rs",   32'(bus.LCD_RS),   32'd1);
      end
      chk("lcd_e",  32'(bus.LCD_E),  32'((k % 8) >= 1 && (k % 8) <= 4));
      chk("lcd_rw", 32'(bus.LCD_RW), 32'd0);
      chk("done0",  32'(bus.done0),  32'(sel == 0 && k == n - 1));
      chk("done1",  32'(bus.done1),  32'(sel == 1 && k == n - 1));
      if (scramble && k == 3) begin
        if (sel == 0) bus.char0 = ~ch;
        else          bus.char1 = ~ch;
      end
      if (drop && k == 3) begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
      end
    end
    @(negedge clk);
    chk("idle_gnt0",  32'(bus.gnt0),  32'd0);
    chk("idle_gnt1",  32'(bus.gnt1),  32'd0);
    chk("idle_done0", 32'(bus.done0), 32'd0);
    chk("idle_done1", 32'(bus.done1), 32'd0);
    chk("idle_e",     32'(bus.LCD_E), 32'd0);
    chk("idle_state", 32'(state),     32'd3);
  endtask

  initial begin
    resetn    = 1'b0;
    bus.req0  = 1'b0;
    bus.req1  = 1'b0;
    bus.line0 = 1'b0;
    bus.line1 = 1'b0;
    bus.col0  = 4'd0;
    bus.col1  = 4'd0;
    bus.char0 = 8'h00;
    bus.char1 = 8'h00;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");

    resetn = 1'b1;
    run_init();

    // Single request, line 0 col 3.
    bus.line0 = 1'b0; bus.col0 = 4'd3; bus.char0 = 8'h41; bus.req0 = 1'b1;
    serve(0, 1'b0, 8'h83, 8'h41, 1'b0, 1'b1);

    // Line 1 col 15; char input is disturbed mid-service.
    bus.line1 = 1'b1; bus.col1 = 4'd15; bus.char1 = 8'h5A; bus.req1 = 1'b1;
    serve(1, 1'b0, 8'hCF, 8'h5A, 1'b1, 1'b1);

    // Both held: alternate 0,1,0,1.
    bus.line0 = 1'b0; bus.col0 = 4'd5; bus.char0 = 8'h30;
    bus.line1 = 1'b1; bus.col1 = 4'd2; bus.char1 = 8'h31;
    bus.req0 = 1'b1; bus.req1 = 1'b1;
    serve(0, 1'b0, 8'h85, 8'h30, 1'b0, 1'b0);
    serve(1, 1'b0, 8'hC2, 8'h31, 1'b0, 1'b0);
    serve(0, 1'b0, 8'h85, 8'h30, 1'b0, 1'b0);
    serve(1, 1'b0, 8'hC2, 8'h31, 1'b0, 1'b1);
    @(negedge clk);
    chk("no_regrant_gnt0", 32'(bus.gnt0), 32'd0);
    chk("no_regrant_gnt1", 32'(bus.gnt1), 32'd0);

    // Consecutive columns on line 0.
    bus.line0 = 1'b0; bus.col0 = 4'd0; bus.char0 = 8'h48; bus.req0 = 1'b1;
    serve(0, 1'b0, 8'h80, 8'h48, 1'b0, 1'b1);
    bus.col0 = 4'd1; bus.char0 = 8'h49; bus.req0 = 1'b1;
`ifdef TEXTLCD_AUTOINC_EN
    serve(0, 1'b1, 8'h00, 8'h49, 1'b0, 1'b1);
`else
    serve(0, 1'b0, 8'h81, 8'h49, 1'b0, 1'b1);
`endif

    // Reset in the middle of a data write.
    bus.line1 = 1'b1; bus.col1 = 4'd0; bus.char1 = 8'h21; bus.req1 = 1'b1;
    repeat (11) @(negedge clk);
    chk("mid_data_state", 32'(state),       32'd5);
    chk("mid_data_rs",    32'(bus.LCD_RS),  32'd1);
    chk("mid_data_gnt1",  32'(bus.gnt1),    32'd1);
    #1 resetn = 1'b0;
    #1 chk_all_zero("async_reset");
    bus.req1 = 1'b0;
    // Request raised during init must wait for ready.
    bus.line0 = 1'b1; bus.col0 = 4'd7; bus.char0 = 8'h77; bus.req0 = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    run_init();
    serve(0, 1'b0, 8'hC7, 8'h77, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
